// File: rtl/freq_div100_pkg.sv
// freq_div100_pkg -- shared helpers for the clock divider.
//   cnt_width(half) : width of a counter that spans 0 .. half-1, never
//                     narrower than one bit (half == 1 still needs a
//                     register to hold the constant zero).
package freq_div100_pkg;

    function automatic int cnt_width(input int half);
        int w;
        w = $clog2(half);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/freq_div100.sv
// freq_div100 -- divides clk by an even integer DIVISOR into a 50% duty
// square wave, plus a one-cycle strobe marking each rising transition of
// that square wave.
//
// Ports
//   clk    : input  sole clock, everything updates on its rising edge
//   rst    : input  synchronous, active-high reset (clears all state)
//   clk100 : output divided clock, period DIVISOR clk cycles, 50% duty
//   tick   : output high for the one clk cycle right after clk100 rises
//
// All state starts at zero at power-up, so the divider runs correctly in
// simulation even when rst is never asserted.
module freq_div100
    import freq_div100_pkg::*;
#(
    parameter int DIVISOR = 100
) (
    input  logic clk,
    input  logic rst,
    output logic clk100,
    output logic tick
);

    localparam int HALF  = DIVISOR / 2;
    localparam int CNT_W = cnt_width(HALF);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    // An odd or too-small ratio cannot give a 50% duty square wave.
    if ((DIVISOR < 2) || ((DIVISOR % 2) != 0)) begin : g_bad_divisor
        $error("freq_div100: DIVISOR must be even and >= 2");
    end

    logic [CNT_W-1:0] count  = '0;
    logic             clk_q  = 1'b0;
    logic             tick_q = 1'b0;

    // The counter wrap and the clk100 toggle happen on the same edge, so
    // clk100 changes exactly once per half-period with no intermediate
    // state. tick is loaded with the new clk100 level only on a toggle
    // edge, so it is high only after a 0->1 transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (count == LAST) begin
            count  <= '0;
            clk_q  <= ~clk_q;
            tick_q <= ~clk_q;
        end else begin
            count  <= count + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign clk100 = clk_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_freq_div100.sv
// tb_freq_div100 -- directed bench for freq_div100 (DIVISOR 100 and 2).
// Expected outputs come from a closed-form model in terms of n, the number
// of non-reset edges since the last reset edge (or power-up):
//   clk100 = (n / half) odd,  tick = (n mod 2*half) == half.
`timescale 1ms/100us
module tb_freq_div100;

    logic clk = 1'b1;
    logic rst = 1'b0;
    logic clk100_a, tick_a;
    logic clk100_b, tick_b;

    int errors = 0;
    int checks = 0;
    int n      = 0;

    typedef struct {
        logic c_a;
        logic t_a;
        logic c_b;
        logic t_b;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    freq_div100 #(.DIVISOR(100)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .clk100 (clk100_a),
        .tick   (tick_a)
    );

    freq_div100 #(.DIVISOR(2)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .clk100 (clk100_b),
        .tick   (tick_b)
    );

    function automatic logic model_clk(input int cnt, input int half);
        return ((cnt / half) % 2) == 1;
    endfunction

    function automatic logic model_tick(input int cnt, input int half);
        return (cnt % (2 * half)) == half;
    endfunction

    task automatic check(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t n=%0d: observed %b expected %b",
                   tag, $time, n, act, exp);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t: observed %0d expected %0d",
                   tag, $time, act, exp);
        end
    endtask

    // One clk cycle: drive rst, take the edge, push the model's answer,
    // then sample 1 ms after the edge and compare against the popped entry.
    task automatic step(input logic r);
        exp_t e;
        rst = r;
        @(posedge clk);
        if (r) n = 0;
        else   n++;
        sb.push_back('{c_a: model_clk(n, 50), t_a: model_tick(n, 50),
                       c_b: model_clk(n, 1),  t_b: model_tick(n, 1)});
        #1;
        e = sb.pop_front();
        check("clk100_div100", clk100_a, e.c_a);
        check("tick_div100",   tick_a,   e.t_a);
        check("clk100_div2",   clk100_b, e.c_b);
        check("tick_div2",     tick_b,   e.t_b);
    endtask

    initial begin
        int rises;
        int ticks;
        int run;
        logic prev;

        // Power-up state, before any edge.
        #1;
        check("powerup_clk100", clk100_a, 1'b0);
        check("powerup_tick",   tick_a,   1'b0);
        check("powerup_clk100_div2", clk100_b, 1'b0);

        // No reset at all: 201 cycles straight from power-up.
        for (int i = 0; i < 201; i++) step(1'b0);

        // Reset held for 3 cycles, then 160 counting cycles.
        for (int i = 0; i < 3; i++) step(1'b1);
        check("held_reset_clk100", clk100_a, 1'b0);
        check("held_reset_tick",   tick_a,   1'b0);
        for (int i = 0; i < 160; i++) step(1'b0);

        // Mid-period reset: release, 69 edges, reset on edge 70 (clk100 high).
        step(1'b1);
        for (int i = 0; i < 69; i++) step(1'b0);
        check("before_abort_clk100", clk100_a, 1'b1);
        step(1'b1);
        check("abort_clk100", clk100_a, 1'b0);
        check("abort_tick",   tick_a,   1'b0);
        for (int i = 0; i < 60; i++) step(1'b0);

        // 1000 cycles after a reset: count rises/ticks, measure each level.
        step(1'b1);
        rises = 0;
        ticks = 0;
        run   = 1;
        prev  = clk100_a;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0);
            if (tick_a === 1'b1) ticks++;
            if (clk100_a !== prev) begin
                if (clk100_a === 1'b1) rises++;
                check_int("level_interval", run, 50);
                run = 1;
            end else begin
                run++;
            end
            prev = clk100_a;
        end
        check_int("rise_count_1000", rises, 10);
        check_int("tick_count_1000", ticks, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_div100.md
FREQ_DIV100 -- requirements
Module: freq_div100

Interface
REQ-001 Parameter: DIVISOR, default 100, integer ratio input-clock : output-clock; even, >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: clk100  output  1  divided clock, period DIVISOR clk cycles, 50% duty.
REQ-005 Port: tick  output  1  one-clk-cycle pulse marking each clk100 rising transition.
REQ-006 All outputs SHALL be driven directly from registers (no combinational path from inputs).

Function
REQ-007 Internal counter width SHALL be clog2(DIVISOR/2), minimum 1 bit; counts 0 .. DIVISOR/2-1.
REQ-008 Each clk rising edge with rst low: if counter == DIVISOR/2-1, counter SHALL wrap to 0 and clk100 SHALL invert; otherwise counter SHALL increment by 1 and clk100 SHALL hold.
REQ-009 Half-period: clk100 SHALL hold each level for exactly DIVISOR/2 clk cycles; full period exactly DIVISOR cycles.
REQ-010 After reset release, the first clk100 0->1 transition SHALL occur at the DIVISOR/2-th rising edge (edge 50 for default); the first 1->0 transition at edge DIVISOR (100).
REQ-011 tick SHALL be 1 exactly in the clk cycle following the edge at which clk100 goes 0->1, and 0 otherwise; tick never asserts on clk100 1->0.
REQ-012 Counter wrap SHALL not glitch clk100: only one register transition per toggle edge.
REQ-013 DIVISOR odd or < 2 SHALL cause an elaboration-time error.
REQ-014 Registers SHALL have power-up initial value 0 (counter, clk100, tick) so the block divides correctly in simulation even if rst is never asserted.

Reset
REQ-015 rst high at a clk rising edge SHALL set counter = 0, clk100 = 0, tick = 0, overriding counting.
REQ-016 Reset asserted mid-period SHALL abort the current period; counting restarts from 0 at the first edge with rst low, giving REQ-010 timing from that edge.
REQ-017 Held reset SHALL keep all outputs at 0 indefinitely.

Structure
REQ-018 Single flat module, no sub-modules; no shared package required; DIVISOR/2 and counter width SHALL be localparams derived from DIVISOR.

Verification
REQ-019 clk period 10 ms, starts high at t=0, no reset, 201 cycles: clk100 = 0 until t=500 ms, 1 during 500-1000 ms, 0 during 1000-1500 ms, 1 from 1500 ms, 0 at 2000 ms.
REQ-020 rst high 3 cycles, then low: clk100 rises on the 50th edge after release, falls on the 100th; tick high only for the cycle after the 50th and 150th edges.
REQ-021 Assert rst for 1 cycle at edge 70 after release (clk100 = 1): clk100 and tick drop to 0 at that edge; next rise 50 edges after rst deassertion.
REQ-022 Run 1000 cycles: count clk100 rising edges = 10, every high and low interval exactly 50 cycles, tick count = 10.
REQ-023 DIVISOR=2 instance: clk100 toggles every edge (period 2 cycles), tick high every other cycle; DIVISOR=7 fails elaboration.
